// File: rtl/datamover_tcdm_slice.sv
// Per-channel TCDM request slice: a shallow request FIFO in front of each master port,
// with an outstanding-transaction cap and a registered response path back upstream.
module datamover_tcdm_slice #(
  parameter int unsigned MP      = 4,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic [MP-1:0]              in_req,
  output logic [MP-1:0]              in_gnt,
  input  logic [MP-1:0][AW-1:0]      in_add,
  input  logic [MP-1:0]              in_wen,
  input  logic [MP-1:0][DW/8-1:0]    in_be,
  input  logic [MP-1:0][DW-1:0]      in_data,
  output logic [MP-1:0][DW-1:0]      in_r_data,
  output logic [MP-1:0]              in_r_valid,
  output logic [MP-1:0]              tcdm_req,
  input  logic [MP-1:0]              tcdm_gnt,
  output logic [MP-1:0][AW-1:0]      tcdm_add,
  output logic [MP-1:0]              tcdm_wen,
  output logic [MP-1:0][DW/8-1:0]    tcdm_be,
  output logic [MP-1:0][DW-1:0]      tcdm_data,
  input  logic [MP-1:0][DW-1:0]      tcdm_r_data,
  input  logic [MP-1:0]              tcdm_r_valid,
  output logic                       busy_o,
  output logic [MP-1:0]              err_o
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned EW  = AW + 1 + BW + DW;
  localparam int unsigned FCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MP-1:0] ch_busy;

  for (genvar c = 0; c < MP; c++) begin : g_ch
    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [FCW-1:0] fc;
    logic [OCW-1:0] oc;
    logic           push, pop, rsp_match;
    logic           err_q, r_valid_q;
    logic [DW-1:0]  r_data_q;

    // Grant looks only at registered counts, so upstream never sees a combinational loop
    assign in_gnt[c]  = !clear_i && (32'(fc) < DEPTH) && ((32'(fc) + 32'(oc)) < MAX_OUT);
    assign push       = in_req[c] && in_gnt[c];
    assign pop        = tcdm_req[c] && tcdm_gnt[c];
    assign rsp_match  = tcdm_r_valid[c] && (oc != '0);
    assign tcdm_req[c] = (fc != '0);
    assign {tcdm_add[c], tcdm_wen[c], tcdm_be[c], tcdm_data[c]} = mem[rd_ptr];
    assign ch_busy[c] = (fc != '0) || (oc != '0);

    assign err_o[c]      = err_q;
    assign in_r_valid[c] = r_valid_q;
    assign in_r_data[c]  = r_data_q;

    // Payload storage, intentionally not reset
    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {in_add[c], in_wen[c], in_be[c], in_data[c]};
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fc     <= '0;
      end else if (clear_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fc     <= '0;
      end else begin
        if (push) wr_ptr <= (32'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + PW'(1);
        if (pop)  rd_ptr <= (32'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        if (push && !pop)      fc <= fc + FCW'(1);
        else if (!push && pop) fc <= fc - FCW'(1);
      end
    end

    // Outstanding count survives clear so in-flight responses still drain
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        oc    <= '0;
        err_q <= 1'b0;
      end else begin
        oc <= oc + OCW'(pop) - OCW'(rsp_match);
        if (tcdm_r_valid[c] && (oc == '0)) err_q <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid_q <= 1'b0;
        r_data_q  <= '0;
      end else begin
        r_valid_q <= tcdm_r_valid[c];
        if (tcdm_r_valid[c]) r_data_q <= tcdm_r_data[c];
      end
    end
  end

  assign busy_o = |ch_busy;

endmodule

// File: tb/tb_datamover_tcdm_slice.sv
// Scoreboard bench for datamover_tcdm_slice: directed scenarios plus a randomised multi-channel load.
module tb_datamover_tcdm_slice;

  localparam int unsigned MP = 4, DEPTH = 2, MAX_OUT = 4, AW = 32, DW = 32;
  localparam int unsigned BW = DW / 8, EW = AW + 1 + BW + DW;
  localparam int unsigned NRND = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, clear_i;
  logic [MP-1:0] in_req, in_gnt, in_wen, in_r_valid;
  logic [MP-1:0][AW-1:0] in_add, tcdm_add;
  logic [MP-1:0][BW-1:0] in_be, tcdm_be;
  logic [MP-1:0][DW-1:0] in_data, in_r_data, tcdm_data, tcdm_r_data;
  logic [MP-1:0] tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, err_o;
  logic busy_o;

  typedef logic [EW-1:0] ent_t;
  typedef struct { string name; logic [127:0] act; logic [127:0] exp; } chk_t;

  ent_t          exp_req [MP][$];
  logic [DW-1:0] exp_rsp [MP][$];
  chk_t          chk_q [$];
  int pend [MP];
  int snd  [MP];
  int n_cmp = 0, n_bad = 0;

  datamover_tcdm_slice #(.MP(MP), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen), .in_be(in_be),
    .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_valid(tcdm_r_valid), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_t e;
    e.name = name;
    e.act  = act;
    e.exp  = exp;
    chk_q.push_back(e);
  endtask

  // Monitor: downstream order, upstream responses, and queued directed checks
  always @(negedge clk) begin
    chk_t e;
    for (int c = 0; c < MP; c++) begin
      if (tcdm_req[c] === 1'b1 && tcdm_gnt[c] === 1'b1) begin
        if (exp_req[c].size() == 0) cmp($sformatf("tcdm_unexpected_ch%0d", c), 128'(1), 128'(0));
        else cmp($sformatf("tcdm_order_ch%0d", c),
                 128'({tcdm_add[c], tcdm_wen[c], tcdm_be[c], tcdm_data[c]}),
                 128'(exp_req[c].pop_front()));
      end
      if (in_r_valid[c] === 1'b1) begin
        if (exp_rsp[c].size() == 0) cmp($sformatf("rsp_unexpected_ch%0d", c), 128'(1), 128'(0));
        else cmp($sformatf("rsp_data_ch%0d", c), 128'(in_r_data[c]), 128'(exp_rsp[c].pop_front()));
      end
    end
    while (chk_q.size() != 0) begin
      e = chk_q.pop_front();
      cmp(e.name, e.act, e.exp);
    end
  end

  // Called at a falling edge: log handshakes, cross the rising edge, release pulse inputs
  task automatic adv();
    logic clr, rst;
    for (int c = 0; c < MP; c++) begin
      if (in_req[c] && in_gnt[c]) begin
        exp_req[c].push_back({in_add[c], in_wen[c], in_be[c], in_data[c]});
        snd[c]++;
      end
      if (tcdm_req[c] && tcdm_gnt[c]) pend[c]++;
      if (tcdm_r_valid[c]) begin
        exp_rsp[c].push_back(tcdm_r_data[c]);
        if (pend[c] > 0) pend[c]--;
      end
    end
    clr = clear_i;
    rst = rst_i;
    @(posedge clk);
    for (int c = 0; c < MP; c++) begin
      if (rst || clr) exp_req[c].delete();
      if (rst) pend[c] = 0;
    end
    #1;
    in_req       = '0;
    tcdm_r_valid = '0;
    clear_i      = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    adv();
  endtask

  task automatic req(input int c, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    in_req[c]  = 1'b1;
    in_add[c]  = a;
    in_wen[c]  = w;
    in_be[c]   = '1;
    in_data[c] = d;
  endtask

  task automatic rsp(input int c, input logic [DW-1:0] d);
    tcdm_r_valid[c] = 1'b1;
    tcdm_r_data[c]  = d;
  endtask

  initial begin
    bit all_done, drained;
    rst_i = 1'b1; clear_i = 1'b0;
    in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
    tcdm_gnt = '1; tcdm_r_valid = '0; tcdm_r_data = '0;
    for (int c = 0; c < MP; c++) begin pend[c] = 0; snd[c] = 0; end
    cyc(); cyc();
    rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 128'(in_gnt), 128'(4'hF));
    chk("rst_tcdm_req", 128'(tcdm_req), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_rvalid", 128'(in_r_valid), 128'(0));
    chk("rst_rdata", 128'(in_r_data), 128'(0));
    adv();

    // Single read on channel 0
    req(0, 32'h100, 1'b1, 32'h0);
    @(negedge clk); chk("a_no_fallthru", 128'(tcdm_req[0]), 128'(0)); chk("a_gnt", 128'(in_gnt[0]), 128'(1)); adv();
    @(negedge clk); chk("a_req", 128'(tcdm_req[0]), 128'(1)); chk("a_add", 128'(tcdm_add[0]), 128'(32'h100));
    chk("a_wen", 128'(tcdm_wen[0]), 128'(1)); adv();
    @(negedge clk); chk("a_req_done", 128'(tcdm_req[0]), 128'(0)); chk("a_busy_wait", 128'(busy_o), 128'(1)); adv();
    rsp(0, 32'hCAFE);
    @(negedge clk); adv();
    @(negedge clk); chk("a_rvalid", 128'(in_r_valid[0]), 128'(1)); chk("a_rdata", 128'(in_r_data[0]), 128'(32'hCAFE));
    chk("a_busy_idle", 128'(busy_o), 128'(0)); adv();
    @(negedge clk); chk("a_rvalid_low", 128'(in_r_valid[0]), 128'(0)); chk("a_rdata_hold", 128'(in_r_data[0]), 128'(32'hCAFE)); adv();

    // Backpressure on channel 1
    tcdm_gnt[1] = 1'b0;
    req(1, 32'h11, 1'b0, 32'hA1);
    @(negedge clk); chk("b_gnt0", 128'(in_gnt[1]), 128'(1)); adv();
    req(1, 32'h12, 1'b0, 32'hA2);
    @(negedge clk); chk("b_gnt1", 128'(in_gnt[1]), 128'(1)); chk("b_head1", 128'(tcdm_add[1]), 128'(32'h11)); adv();
    req(1, 32'h13, 1'b0, 32'hA3);
    @(negedge clk); chk("b_gnt_full", 128'(in_gnt[1]), 128'(0)); chk("b_head2", 128'(tcdm_add[1]), 128'(32'h11)); adv();
    req(1, 32'h13, 1'b0, 32'hA3); tcdm_gnt[1] = 1'b1;
    @(negedge clk); chk("b_full_pop", 128'(in_gnt[1]), 128'(0)); chk("b_head3", 128'(tcdm_data[1]), 128'(32'hA1)); adv();
    req(1, 32'h13, 1'b0, 32'hA3);
    @(negedge clk); chk("b_gnt_reopen", 128'(in_gnt[1]), 128'(1)); chk("b_head4", 128'(tcdm_add[1]), 128'(32'h12)); adv();
    @(negedge clk); chk("b_head5", 128'(tcdm_add[1]), 128'(32'h13)); adv();
    for (int k = 0; k < 3; k++) begin rsp(1, 32'hB1 + 32'(k)); cyc(); end
    @(negedge clk); chk("b_idle", 128'(busy_o), 128'(0)); adv();

    // Outstanding cap on channel 3
    for (int k = 0; k < 7; k++) begin
      if (k < 6) req(3, 32'h300 + 32'(k), 1'b1, 32'h0);
      else rsp(3, 32'hD1);
      @(negedge clk); chk($sformatf("c_cap_k%0d", k), 128'(in_gnt[3]), 128'(k < 4)); adv();
    end
    @(negedge clk); chk("c_reopen", 128'(in_gnt[3]), 128'(1)); adv();
    for (int k = 0; k < 3; k++) begin rsp(3, 32'hD2 + 32'(k)); cyc(); end
    @(negedge clk); chk("c_idle", 128'(busy_o), 128'(0)); adv();

    // Clear on channel 2 with two queued and one outstanding
    req(2, 32'h21, 1'b0, 32'hC1); cyc();
    req(2, 32'h22, 1'b0, 32'hC2); cyc();
    req(2, 32'h23, 1'b0, 32'hC3); tcdm_gnt[2] = 1'b0; cyc();
    req(2, 32'h24, 1'b0, 32'hC4); clear_i = 1'b1;
    @(negedge clk); chk("d_gnt_clear", 128'(in_gnt[2]), 128'(0)); chk("d_req_pre", 128'(tcdm_req[2]), 128'(1)); adv();
    tcdm_gnt[2] = 1'b1;
    @(negedge clk); chk("d_req_dropped", 128'(tcdm_req[2]), 128'(0)); chk("d_busy_drain", 128'(busy_o), 128'(1));
    chk("d_gnt_after", 128'(in_gnt[2]), 128'(1)); adv();
    rsp(2, 32'hE1);
    @(negedge clk); chk("d_busy", 128'(busy_o), 128'(1)); adv();
    @(negedge clk); chk("d_rvalid", 128'(in_r_valid[2]), 128'(1)); chk("d_idle", 128'(busy_o), 128'(0)); adv();

    // Spurious response on channel 2
    rsp(2, 32'h5A);
    @(negedge clk); chk("e_err_pre", 128'(err_o), 128'(0)); adv();
    @(negedge clk); chk("e_err", 128'(err_o), 128'(4'b0100)); chk("e_rvalid", 128'(in_r_valid[2]), 128'(1));
    chk("e_no_underflow", 128'(busy_o), 128'(0)); adv();
    @(negedge clk); chk("e_sticky", 128'(err_o), 128'(4'b0100)); adv();

    // Reset mid-transaction, then a late response
    tcdm_gnt[0] = 1'b0;
    req(0, 32'h31, 1'b0, 32'h0); req(1, 32'h41, 1'b1, 32'h0); cyc();
    req(0, 32'h32, 1'b0, 32'h0); cyc();
    rst_i = 1'b1;
    @(negedge clk); chk("f_busy", 128'(busy_o), 128'(1)); adv();
    rst_i = 1'b0;
    rsp(1, 32'h77);
    @(negedge clk); chk("r_err", 128'(err_o), 128'(0)); chk("r_busy", 128'(busy_o), 128'(0));
    chk("r_tcdm_req", 128'(tcdm_req), 128'(0)); chk("r_gnt", 128'(in_gnt), 128'(4'hF)); adv();
    @(negedge clk); chk("r_late_err", 128'(err_o), 128'(4'b0010)); adv();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    tcdm_gnt = '1;

    // All channels loaded with random stalls
    for (int c = 0; c < MP; c++) snd[c] = 0;
    all_done = 1'b0;
    for (int t = 0; t < 400 && !all_done; t++) begin
      for (int c = 0; c < MP; c++) begin
        tcdm_gnt[c] = ($urandom_range(3) != 0);
        if (snd[c] < int'(NRND) && $urandom_range(3) != 0)
          req(c, 32'((c << 8) | snd[c]), 1'(snd[c] & 1), 32'($urandom));
        if (pend[c] > 0 && $urandom_range(2) != 0) rsp(c, 32'($urandom));
      end
      cyc();
      all_done = 1'b1;
      for (int c = 0; c < MP; c++) begin
        chk($sformatf("g_cap_ch%0d", c), 128'((exp_req[c].size() + pend[c]) <= int'(MAX_OUT)), 128'(1));
        if (snd[c] < int'(NRND)) all_done = 1'b0;
      end
    end
    chk("g_all_sent", 128'(all_done), 128'(1));
    tcdm_gnt = '1;
    drained = 1'b0;
    for (int t = 0; t < 100 && !drained; t++) begin
      for (int c = 0; c < MP; c++) if (pend[c] > 0) rsp(c, 32'($urandom));
      cyc();
      drained = 1'b1;
      for (int c = 0; c < MP; c++) if (pend[c] != 0 || exp_req[c].size() != 0) drained = 1'b0;
    end
    chk("g_drained", 128'(drained), 128'(1));
    cyc();
    @(negedge clk); chk("g_busy_end", 128'(busy_o), 128'(0)); chk("g_err_end", 128'(err_o), 128'(0)); adv();
    cyc();
    for (int c = 0; c < MP; c++) chk($sformatf("g_rsp_left_ch%0d", c), 128'(exp_rsp[c].size()), 128'(0));
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
